keccak_arbiter: RTL and testbench

- Shares one keccak core among NUM_REQ independent requesters, one hash job at a time.
- Round-robin grant; the grant is locked for a whole job: input stream (header + blocks) into the core, then exactly out_len output words back to the same requester.
- Sits between requester-side stream interfaces (active-high valid/ready) and the keccak top-level pins (active-low valid_in/ready_in).

---
 rtl/keccak_arbiter.sv | 157 +++++++++++++++
 tb/tb_keccak_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_arbiter.sv
// Round-robin arbiter sharing one keccak core among NUM_REQ requesters.
// A grant holds for a whole job: input stream into the core, then out_len words back.
module keccak_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W       = 64,
  parameter int LEN_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*W-1:0]     req_data,
  input  logic [NUM_REQ*LEN_W-1:0] req_out_len,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [W-1:0]             rsp_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     core_valid_n,
  output logic                     core_ready_n,
  output logic [W-1:0]             core_data_in,
  input  logic                     core_ready_out,
  input  logic                     core_valid_out,
  input  logic [W-1:0]             core_data_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [LEN_W-1:0]   out_cnt_q, out_cnt_d;

  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   owner_next;
  logic [LEN_W-1:0]   winner_len;
  logic [NUM_REQ-1:0] owner_onehot;
  logic               any_req;
  logic               own_valid;
  logic               own_last;
  logic               own_rsp_ready;
  logic               feed_xfer;
  logic               drain_xfer;

  // Scan downward so the last hit is the closest requester at or after rr_q.
  always_comb begin
    logic [IDX_W:0] sum;
    winner  = rr_q;
    any_req = 1'b0;
    sum     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_q} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      if (req_valid[sum[IDX_W-1:0]]) begin
        winner  = sum[IDX_W-1:0];
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    winner_len   = '0;
    core_data_in = '0;
    owner_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        winner_len = req_out_len[i*LEN_W +: LEN_W];
      end
      if (owner_q == IDX_W'(i)) begin
        core_data_in    = req_data[i*W +: W];
        owner_onehot[i] = 1'b1;
      end
    end
  end

  assign own_valid     = req_valid[owner_q];
  assign own_last      = req_last[owner_q];
  assign own_rsp_ready = rsp_ready[owner_q];
  assign owner_next    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  assign busy     = (state_q != IDLE);
  assign grant    = busy ? owner_onehot : '0;
  assign rsp_data = core_data_out;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    out_cnt_d    = out_cnt_q;
    req_ready    = '0;
    rsp_valid    = '0;
    core_valid_n = 1'b1;
    core_ready_n = 1'b1;
    feed_xfer    = 1'b0;
    drain_xfer   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d   = FEED;
          owner_d   = winner;
          out_cnt_d = winner_len;
        end
      end
      FEED: begin
        feed_xfer    = own_valid & core_ready_out;
        req_ready    = owner_onehot & {NUM_REQ{core_ready_out}};
        core_valid_n = ~feed_xfer;
        // A zero-length job skips DRAIN, so the pointer must advance here too.
        if (feed_xfer && own_last) begin
          if (out_cnt_q == '0) begin
            state_d = IDLE;
            rr_d    = owner_next;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        core_ready_n = ~own_rsp_ready;
        rsp_valid    = owner_onehot & {NUM_REQ{core_valid_out}};
        drain_xfer   = core_valid_out & own_rsp_ready;
        if (drain_xfer) begin
          out_cnt_d = out_cnt_q - 1'b1;
          if (out_cnt_q == LEN_W'(1)) begin
            state_d = IDLE;
            rr_d    = owner_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_keccak_arbiter.sv
// Scoreboard bench for keccak_arbiter: requester and core models drive the pins,
// expected core words, response words and grant order are queued when jobs are planned.
module tb_keccak_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int LW = 16;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, req_last;
  logic [N*W-1:0] req_data;
  logic [N*LW-1:0] req_out_len;
  logic [N-1:0]   rsp_valid, rsp_ready, grant;
  logic [W-1:0]   rsp_data, core_data_in, core_data_out;
  logic           busy, core_valid_n, core_ready_n, core_ready_out, core_valid_out;

  keccak_arbiter #(.NUM_REQ(N), .W(W), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_data(req_data), .req_out_len(req_out_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .grant(grant), .busy(busy),
    .core_valid_n(core_valid_n), .core_ready_n(core_ready_n), .core_data_in(core_data_in),
    .core_ready_out(core_ready_out), .core_valid_out(core_valid_out), .core_data_out(core_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Job table: requester, input word count, output word count, words accepted so far.
  int jr[32], jnw[32], jol[32], jsent[32];
  int nJobs = 0;
  int planSeq = 0;

  logic [W-1:0]   inQ[$];
  logic [N+W-1:0] rspQ[$];
  logic [N-1:0]   grantQ[$];
  int             coreNwQ[$];
  int             coreOlQ[$];

  int coreWrites = 0, coreOutLeft = 0, coreSeq = 0;
  int coreStall = 0, rspStall = 0;
  logic [N-1:0] accIn = '0;
  bit coreWr = 0, coreRd = 0;
  bit prevBusy = 0, seenJob = 0, checkGap = 0, noRsp = 0;
  int gap = 0;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] wordOf(input int r, input int id, input int w);
    return {8'(r), 8'(id), 16'h5A5A, 32'(w)};
  endfunction

  function automatic int curJob(input int r);
    for (int j = 0; j < nJobs; j++)
      if (jr[j] == r && jsent[j] < jnw[j]) return j;
    return -1;
  endfunction

  // Plans one job; callers plan jobs in the order the arbiter is expected to serve them.
  task automatic applyStimulus(input int r, input int nw, input int ol);
    int id;
    id = nJobs;
    jr[id] = r; jnw[id] = nw; jol[id] = ol; jsent[id] = 0;
    nJobs++;
    for (int w = 0; w < nw; w++) inQ.push_back(wordOf(r, id, w));
    grantQ.push_back(N'(1 << r));
    coreNwQ.push_back(nw);
    coreOlQ.push_back(ol);
    for (int k = 0; k < ol; k++) begin
      rspQ.push_back({N'(1 << r), 64'hC0DE_0000_0000_0000 | 64'(planSeq)});
      planSeq++;
    end
  endtask

  task automatic clearModel();
    nJobs = 0; planSeq = 0;
    inQ.delete(); rspQ.delete(); grantQ.delete(); coreNwQ.delete(); coreOlQ.delete();
    coreWrites = 0; coreOutLeft = 0; coreSeq = 0;
    accIn = '0; coreWr = 0; coreRd = 0;
    prevBusy = 0; seenJob = 0; gap = 0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n;
    bit done;
    n = 0; done = 0;
    while (!done && n < budget) begin
      @(negedge clk); #2;
      done = (curJob(0) < 0) && (curJob(1) < 0) && (curJob(2) < 0) && (curJob(3) < 0)
             && inQ.size() == 0 && rspQ.size() == 0 && grantQ.size() == 0 && !busy;
      n++;
    end
    checkOutput({tag, "_done"}, done, 1);
  endtask

  // Requester and core models: apply handshakes seen at the previous negedge, then redrive.
  initial begin
    logic [N-1:0]    v, l;
    logic [N*W-1:0]  d;
    logic [N*LW-1:0] o;
    int j;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        for (int r = 0; r < N; r++) begin
          if (accIn[r]) begin
            j = curJob(r);
            if (j >= 0) jsent[j]++;
          end
        end
        if (coreWr && coreNwQ.size() > 0) begin
          coreWrites++;
          if (coreWrites >= coreNwQ[0]) begin
            coreOutLeft = coreOlQ[0];
            void'(coreNwQ.pop_front());
            void'(coreOlQ.pop_front());
            coreWrites = 0;
          end
        end
        if (coreRd && coreOutLeft > 0) begin
          coreSeq++;
          coreOutLeft--;
        end
      end
      accIn = '0; coreWr = 0; coreRd = 0;
      v = '0; l = '0; d = '0; o = '0;
      for (int r = 0; r < N; r++) begin
        j = curJob(r);
        if (j >= 0) begin
          v[r] = 1'b1;
          l[r] = (jsent[j] == jnw[j] - 1);
          d[r*W +: W] = wordOf(r, j, jsent[j]);
          o[r*LW +: LW] = LW'(jol[j]);
        end
      end
      req_valid = v; req_last = l; req_data = d; req_out_len = o;
      core_valid_out = (coreOutLeft > 0);
      core_data_out  = 64'hC0DE_0000_0000_0000 | 64'(coreSeq);
      core_ready_out = (coreStall == 0);
      if (coreStall > 0) coreStall--;
      rsp_ready = (rspStall == 0) ? '1 : '0;
      if (rspStall > 0) rspStall--;
    end
  end

  // Monitor: records handshakes and pops the scoreboards mid-cycle.
  initial begin
    logic [N-1:0] hs;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int r = 0; r < N; r++)
          if (req_valid[r] && req_ready[r]) accIn[r] = 1'b1;
        if (!core_valid_n && core_ready_out) begin
          coreWr = 1;
          if (inQ.size() == 0) checkOutput("core_in_unexpected", !core_valid_n, 0);
          else checkOutput("core_in_data", core_data_in, inQ.pop_front());
        end
        coreRd = !core_ready_n && core_valid_out;
        hs = rsp_valid & rsp_ready;
        if (hs != '0) begin
          if (rspQ.size() == 0) checkOutput("rsp_unexpected", hs, 0);
          else checkOutput("rsp_word", {hs, rsp_data}, rspQ.pop_front());
        end
        if (busy && !prevBusy) begin
          if (grantQ.size() == 0) checkOutput("busy_unexpected", busy, 0);
          else checkOutput("grant_owner", grant, grantQ.pop_front());
          if (checkGap && seenJob) checkOutput("idle_gap", gap, 1);
          seenJob = 1;
          gap = 0;
        end
        if (!busy) gap++;
        prevBusy = busy;
        if (!core_ready_out) begin
          checkOutput("stall_req_ready", req_ready, 0);
          checkOutput("stall_core_valid_n", core_valid_n, 1);
        end
        if (rsp_ready == '0) checkOutput("rsp_stall_core_ready_n", core_ready_n, 1);
        if (noRsp) checkOutput("no_rsp_valid", rsp_valid, 0);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bit seen;
    rst = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; req_out_len = '0;
    rsp_ready = '1; core_ready_out = 1'b1; core_valid_out = 1'b0; core_data_out = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_grant", grant, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_core_valid_n", core_valid_n, 1);
    checkOutput("reset_core_ready_n", core_ready_n, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] all four requesting, order 0,1,2,3,0");
    checkGap = 1; seenJob = 0;
    applyStimulus(0, 2, 2);
    applyStimulus(1, 2, 2);
    applyStimulus(2, 2, 2);
    applyStimulus(3, 2, 2);
    applyStimulus(0, 2, 2);
    waitDone("rr4", 300);
    checkGap = 0;

    $display("[TB] single requester 0, 3 words in, 4 out");
    applyStimulus(0, 3, 4);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_valid[0] && n < 5);
    checkOutput("t1_decision_grant", grant, 0);
    @(negedge clk);
    checkOutput("t1_grant", grant, 4'b0001);
    checkOutput("t1_busy", busy, 1);
    waitDone("t1", 100);
    checkOutput("t1_idle_grant", grant, 0);

    $display("[TB] core backpressure mid-FEED");
    applyStimulus(1, 4, 1);
    n = 0; seen = 0;
    while (!seen && n < 20) begin @(negedge clk); #2; seen = coreWr; n++; end
    checkOutput("t3_first_write", seen, 1);
    coreStall = 5;
    waitDone("t3", 100);

    $display("[TB] requester backpressure in DRAIN");
    applyStimulus(2, 1, 5);
    n = 0; seen = 0;
    while (!seen && n < 20) begin @(negedge clk); #2; seen = ((rsp_valid & rsp_ready) != '0); n++; end
    checkOutput("t4_first_rsp", seen, 1);
    rspStall = 3;
    waitDone("t4", 100);

    $display("[TB] reset mid-DRAIN");
    applyStimulus(2, 1, 4);
    n = 0; seen = 0;
    while (!seen && n < 20) begin @(negedge clk); #2; seen = ((rsp_valid & rsp_ready) != '0); n++; end
    checkOutput("t6_in_drain", seen, 1);
    rst = 1'b0;
    #1;
    checkOutput("t6_grant", grant, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_req_ready", req_ready, 0);
    checkOutput("t6_rsp_valid", rsp_valid, 0);
    checkOutput("t6_core_valid_n", core_valid_n, 1);
    checkOutput("t6_core_ready_n", core_ready_n, 1);
    clearModel();
    repeat (2) @(negedge clk);
    clearModel();
    rst = 1'b1;
    applyStimulus(1, 1, 1);
    applyStimulus(3, 1, 1);
    waitDone("t6_after", 100);

    $display("[TB] zero-length output job");
    noRsp = 1;
    applyStimulus(0, 1, 0);
    waitDone("t5", 50);
    repeat (2) @(negedge clk);
    noRsp = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
